// File: rtl/spi_cmd_sender_pkg.sv
// Command codes, payload lengths and frame packing shared by the SPI sender and receiver.
package spi_cmd_sender_pkg;

   localparam int SPI_CMD_BITS    = 4;
   localparam int SPI_PAYLOAD_MAX = 12;
   localparam int SPI_FRAME_W     = SPI_CMD_BITS + SPI_PAYLOAD_MAX;

   localparam logic [3:0] CMD_SKY    = 4'd0;
   localparam logic [3:0] CMD_FLOOR  = 4'd1;
   localparam logic [3:0] CMD_LEAK   = 4'd2;
   localparam logic [3:0] CMD_OTHER  = 4'd3;
   localparam logic [3:0] CMD_VSHIFT = 4'd4;
   localparam logic [3:0] CMD_VINF   = 4'd5;

   localparam logic [7:0] LEN_SKY     = 8'd6;
   localparam logic [7:0] LEN_FLOOR   = 8'd6;
   localparam logic [7:0] LEN_LEAK    = 8'd6;
   localparam logic [7:0] LEN_OTHER   = 8'd12;
   localparam logic [7:0] LEN_VSHIFT  = 8'd6;
   localparam logic [7:0] LEN_VINF    = 8'd1;
   localparam logic [7:0] LEN_DEFAULT = 8'd1;

   typedef struct packed {
      logic [3:0]  cmd;
      logic [11:0] data;
   } spi_cmd_word_t;

   function automatic logic [7:0] cmd_len(input logic [3:0] cmd);
      case (cmd)
         CMD_SKY:    return LEN_SKY;
         CMD_FLOOR:  return LEN_FLOOR;
         CMD_LEAK:   return LEN_LEAK;
         CMD_OTHER:  return LEN_OTHER;
         CMD_VSHIFT: return LEN_VSHIFT;
         CMD_VINF:   return LEN_VINF;
         default:    return LEN_DEFAULT;
      endcase
   endfunction

   // Left-justify the frame so the next bit to send is always bit 15.
   function automatic logic [SPI_FRAME_W-1:0] frame_pack(input logic [3:0] cmd,
                                                         input logic [11:0] data);
      logic [7:0] pad;
      pad = 8'(SPI_PAYLOAD_MAX) - cmd_len(cmd);
      return {cmd, data << pad};
   endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// Depth-4 synchronous command FIFO; full/empty derive from an occupancy counter.
module spi_cmd_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push, w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_pop  = i_pop && !o_empty;
   // A push into a full FIFO is fine when the same cycle pops.
   assign w_do_push = i_push && (!o_full || w_do_pop);
   assign o_data    = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/spi_cmd_sender.sv
// SPI mode-0 transmitter for {cmd, payload} register-write frames, MSB first.
// Define SPI_CMD_SENDER_FIFO_EN to put a 4-entry command FIFO in front of the FSM.
module spi_cmd_sender
   import spi_cmd_sender_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int GAP     = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid,
   output logic        o_ready,
   input  logic [3:0]  i_cmd,
   input  logic [11:0] i_data,
   output logic        o_sclk,
   output logic        o_ss_n,
   output logic        o_mosi,
   output logic        o_busy,
   output logic        o_done
);
   // state | meaning
   // IDLE  | bus idle, waiting for a command
   // SETUP | ss_n low, first bit on mosi, sclk low
   // HIGH  | sclk high, receiver samples
   // LOW   | sclk low, next bit presented
   // HOLD  | sclk low after the last bit, ss_n still low
   // GAP   | ss_n high spacing before the next frame
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_SETUP = 3'd1;
   localparam logic [2:0] S_HIGH  = 3'd2;
   localparam logic [2:0] S_LOW   = 3'd3;
   localparam logic [2:0] S_HOLD  = 3'd4;
   localparam logic [2:0] S_GAP   = 3'd5;

   localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);
   localparam logic [7:0] GAP_M1 = 8'(GAP - 1);

   logic [2:0]             r_state, w_state_nxt;
   logic [7:0]             r_phase, w_phase_nxt;
   logic [7:0]             r_bit, w_bit_nxt;
   logic [SPI_FRAME_W-1:0] r_shift, w_shift_nxt;
   logic                   r_sclk, r_ss_n, r_mosi, r_done, r_busy;
   logic                   w_start, w_in_frame;
   spi_cmd_word_t          w_word;

`ifdef SPI_CMD_SENDER_FIFO_EN
   logic          w_can_start, w_push, w_pop, w_full, w_empty;
   spi_cmd_word_t w_head;

   assign w_can_start = (r_state == S_IDLE) || (r_state == S_GAP && r_phase == 8'd0);
   // With an empty FIFO a ready FSM launches straight from the inputs.
   assign w_start = w_can_start && (!w_empty || i_valid);
   assign w_pop   = w_can_start && !w_empty;
   assign w_push  = i_valid && !w_full && !(w_can_start && w_empty);
   assign o_ready = !w_full;

   always_comb begin
      w_word = w_head;
      if (w_empty) begin
         w_word.cmd  = i_cmd;
         w_word.data = i_data;
      end
   end

   spi_cmd_fifo #(.WIDTH(SPI_FRAME_W), .DEPTH(4)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_data  ({i_cmd, i_data}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );
`else
   logic r_ready;

   assign w_start = i_valid && r_ready;
   assign o_ready = r_ready;

   always_comb begin
      w_word.cmd  = i_cmd;
      w_word.data = i_data;
   end

   always_ff @(posedge clk) begin
      if (reset) r_ready <= 1'b1;
      else       r_ready <= (w_state_nxt == S_IDLE);
   end
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_bit_nxt   = r_bit;
      w_shift_nxt = r_shift;
      if (w_start) begin
         w_state_nxt = S_SETUP;
         w_phase_nxt = DIV_M1;
         w_bit_nxt   = 8'(SPI_CMD_BITS - 1) + cmd_len(w_word.cmd);
         w_shift_nxt = frame_pack(w_word.cmd, w_word.data);
      end else begin
         case (r_state)
            S_IDLE: ;
            S_SETUP, S_LOW: begin
               if (r_phase == 8'd0) begin
                  w_state_nxt = S_HIGH;
                  w_phase_nxt = DIV_M1;
               end else
                  w_phase_nxt = r_phase - 8'd1;
            end
            S_HIGH: begin
               if (r_phase == 8'd0) begin
                  w_phase_nxt = DIV_M1;
                  if (r_bit == 8'd0)
                     w_state_nxt = S_HOLD;
                  else begin
                     w_state_nxt = S_LOW;
                     w_bit_nxt   = r_bit - 8'd1;
                     w_shift_nxt = r_shift << 1;
                  end
               end else
                  w_phase_nxt = r_phase - 8'd1;
            end
            S_HOLD: begin
               if (r_phase == 8'd0) begin
                  w_state_nxt = S_GAP;
                  w_phase_nxt = GAP_M1;
               end else
                  w_phase_nxt = r_phase - 8'd1;
            end
            S_GAP: begin
               if (r_phase == 8'd0) w_state_nxt = S_IDLE;
               else                 w_phase_nxt = r_phase - 8'd1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   assign w_in_frame = (w_state_nxt == S_SETUP) || (w_state_nxt == S_HIGH) ||
                       (w_state_nxt == S_LOW)   || (w_state_nxt == S_HOLD);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_phase <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_sclk  <= 1'b0;
         r_ss_n  <= 1'b1;
         r_mosi  <= 1'b0;
         r_done  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_phase <= w_phase_nxt;
         r_bit   <= w_bit_nxt;
         r_shift <= w_shift_nxt;
         r_sclk  <= (w_state_nxt == S_HIGH);
         r_ss_n  <= !w_in_frame;
         r_mosi  <= w_in_frame ? w_shift_nxt[SPI_FRAME_W-1] : 1'b0;
         r_done  <= (r_state == S_HOLD) && (w_state_nxt == S_GAP);
         r_busy  <= (w_state_nxt != S_IDLE);
      end
   end

   assign o_sclk = r_sclk;
   assign o_ss_n = r_ss_n;
   assign o_mosi = r_mosi;
   assign o_done = r_done;
   assign o_busy = r_busy;

endmodule

// File: tb/tb_spi_cmd_sender.sv
// Self-checking bench for spi_cmd_sender: frame vectors plus handshake and reset sequences.
module tb_spi_cmd_sender;
   localparam int DIV  = 4;
   localparam int GAPC = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid;
   logic [3:0]  i_cmd;
   logic [11:0] i_data;
   logic        o_ready, o_sclk, o_ss_n, o_mosi, o_busy, o_done;

   int n_tests = 0;
   int n_fail  = 0;

   spi_cmd_sender #(.CLK_DIV(DIV), .GAP(GAPC)) dut (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_cmd   (i_cmd),
      .i_data  (i_data),
      .o_sclk  (o_sclk),
      .o_ss_n  (o_ss_n),
      .o_mosi  (o_mosi),
      .o_busy  (o_busy),
      .o_done  (o_done)
   );

   always #5 clk = ~clk;

   int edge_n = 0;
   always @(posedge clk) edge_n++;

   // Bus monitor and receiver model, sampled on the falling edge.
   logic        prev_sclk = 1'b0, prev_ss_n = 1'b1;
   logic [15:0] cap_bits = '0, fr_bits = '0;
   int          cap_n = 0, fr_n = 0, low_cnt = 0, high_run = 0, last_gap = 0;
   int          done_cnt = 0, done_cyc = 0, frames = 0;
   logic [15:0] fr_log[$];
   logic [5:0]  rx_sky = '0, rx_otherx = '0, rx_othery = '0;

   function automatic int tb_len(input logic [3:0] c);
      case (c)
         4'd0, 4'd1, 4'd2, 4'd4: return 6;
         4'd3:                   return 12;
         default:                return 1;
      endcase
   endfunction

   task automatic rx_apply(input logic [15:0] b, input int n);
      logic [3:0]  c;
      logic [11:0] p;
      int          l;
      if (n < 5) return;
      c = 4'(b >> (n - 4));
      l = tb_len(c);
      if (n != 4 + l) return;
      p = 12'(b & ((16'd1 << l) - 16'd1));
      case (c)
         4'd0: rx_sky = p[5:0];
         4'd3: begin rx_otherx = p[11:6]; rx_othery = p[5:0]; end
         default: ;
      endcase
   endtask

   always @(negedge clk) begin
      if (!o_ss_n && prev_ss_n) begin
         cap_n = 0; cap_bits = '0; low_cnt = 0; last_gap = high_run;
      end
      if (o_ss_n && !prev_ss_n) begin
         fr_bits = cap_bits; fr_n = cap_n; frames++;
         fr_log.push_back(cap_bits);
         rx_apply(cap_bits, cap_n);
      end
      if (o_sclk && !prev_sclk) begin
         cap_bits = {cap_bits[14:0], o_mosi};
         cap_n++;
      end
      if (!o_ss_n) low_cnt++;
      high_run = o_ss_n ? high_run + 1 : 0;
      if (o_done) begin done_cnt++; done_cyc = edge_n; end
      prev_sclk = o_sclk;
      prev_ss_n = o_ss_n;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send(input logic [3:0] c, input logic [11:0] d, output int acc);
      int t = 0;
      i_cmd = c; i_data = d; i_valid = 1'b1;
      while (!o_ready && t < 2000) begin @(posedge clk); #1; t++; end
      if (t >= 2000) check("accept_timeout", 32'(t), 32'd0);
      acc = edge_n;
      @(posedge clk); #1;
      i_valid = 1'b0;
   endtask

   task automatic wait_frame_end(input int d0);
      int t = 0;
      while ((done_cnt == d0 || o_busy) && t < 2000) begin @(posedge clk); #1; t++; end
      if (t >= 2000) check("frame_timeout", 32'(t), 32'd0);
   endtask

   typedef struct {
      logic [3:0]  cmd;
      logic [11:0] data;
      logic [15:0] bits;
      int          nb;
   } vec_t;

   vec_t vecs[9];

   initial begin
      int acc, acc2, d0, f0, nacc, bad_ready, t;

      vecs[0] = '{4'd0,  12'h02A, 16'h002A, 10};
      vecs[1] = '{4'd3,  12'hABC, 16'h3ABC, 16};
      vecs[2] = '{4'd5,  12'h001, 16'h000B, 5};
      vecs[3] = '{4'd9,  12'h000, 16'h0012, 5};
      vecs[4] = '{4'd1,  12'hFC5, 16'h0045, 10};
      vecs[5] = '{4'd4,  12'h03F, 16'h013F, 10};
      vecs[6] = '{4'd2,  12'h815, 16'h0095, 10};
      vecs[7] = '{4'd15, 12'hFFE, 16'h001E, 5};
      vecs[8] = '{4'd6,  12'h001, 16'h000D, 5};

      reset = 1'b1; i_valid = 1'b0; i_cmd = '0; i_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sclk",  32'(o_sclk),  32'd0);
      check("rst_ss_n",  32'(o_ss_n),  32'd1);
      check("rst_mosi",  32'(o_mosi),  32'd0);
      check("rst_busy",  32'(o_busy),  32'd0);
      check("rst_done",  32'(o_done),  32'd0);
      check("rst_ready", 32'(o_ready), 32'd1);
      reset = 1'b0;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) begin
         d0 = done_cnt;
         send(vecs[i].cmd, vecs[i].data, acc);
         wait_frame_end(d0);
         check($sformatf("v%0d_nbits", i), 32'(fr_n), 32'(vecs[i].nb));
         check($sformatf("v%0d_bits", i), 32'(fr_bits), 32'(vecs[i].bits));
         check($sformatf("v%0d_ss_low", i), 32'(low_cnt), 32'(DIV * (2 * vecs[i].nb + 1)));
         check($sformatf("v%0d_done_lat", i), 32'(done_cyc - acc), 32'(1 + DIV * (2 * vecs[i].nb + 1)));
         check($sformatf("v%0d_done_cnt", i), 32'(done_cnt - d0), 32'd1);
         check($sformatf("v%0d_ready", i), 32'(o_ready), 32'd1);
      end
      check("rx_sky",    32'(rx_sky),    32'h2A);
      check("rx_otherx", 32'(rx_otherx), 32'h2A);
      check("rx_othery", 32'(rx_othery), 32'h3C);

`ifndef SPI_CMD_SENDER_FIFO_EN
      // Hold a second command across a running frame: accepted once, with the held values.
      f0 = frames; d0 = done_cnt; nacc = 0; bad_ready = 0; t = 0; acc2 = 0;
      send(4'd5, 12'h001, acc);
      i_cmd = 4'd9; i_data = 12'h000; i_valid = 1'b1;
      while (t < 2000 && !(frames >= f0 + 2 && !o_busy)) begin
         if (o_busy && o_ready) bad_ready++;
         if (i_valid && o_ready) begin
            nacc++; acc2 = edge_n;
            @(posedge clk); #1;
            i_valid = 1'b0; i_cmd = 4'hF; i_data = 12'hFFF;
         end else begin
            @(posedge clk); #1;
         end
         t++;
      end
      repeat (20) @(posedge clk);
      #1;
      check("hold_accepts",   32'(nacc),         32'd1);
      check("hold_ready_low", 32'(bad_ready),    32'd0);
      check("hold_frames",    32'(frames - f0),  32'd2);
      check("hold_done_cnt",  32'(done_cnt - d0), 32'd2);
      check("hold_bits",      32'(fr_bits),      32'h12);
      check("hold_nbits",     32'(fr_n),         32'd5);
      check("hold_gap_min",   32'(last_gap >= GAPC), 32'd1);
      check("hold_spacing",   32'(acc2 - acc >= 2 + DIV * 11 + GAPC - 1), 32'd1);
`else
      // Five back-to-back commands: the sender plus a 4-deep FIFO hold them all in order.
      f0 = frames;
      for (int i = 0; i < 5; i++) send(vecs[i].cmd, vecs[i].data, acc);
      t = 0;
      while (t < 4000 && !(frames >= f0 + 5 && !o_busy)) begin @(posedge clk); #1; t++; end
      check("fifo_frames", 32'(frames - f0), 32'd5);
      for (int i = 0; i < 5; i++)
         if (f0 + i < fr_log.size())
            check($sformatf("fifo_order%0d", i), 32'(fr_log[f0 + i]), 32'(vecs[i].bits));
`endif

      // Reset during the fifth SCLK high of a SKY frame.
      d0 = done_cnt;
      send(4'd0, 12'h015, acc);
      @(negedge clk); #1;
      t = 0;
      while (cap_n < 5 && t < 500) begin @(negedge clk); #1; t++; end
      if (t >= 500) check("rst_mid_timeout", 32'(t), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_ss_n",  32'(o_ss_n),  32'd1);
      check("mid_rst_sclk",  32'(o_sclk),  32'd0);
      check("mid_rst_mosi",  32'(o_mosi),  32'd0);
      check("mid_rst_busy",  32'(o_busy),  32'd0);
      check("mid_rst_ready", 32'(o_ready), 32'd1);
      reset = 1'b0;
      repeat (150) @(posedge clk);
      #1;
      check("mid_rst_no_done", 32'(done_cnt - d0), 32'd0);
      check("mid_rst_sky",     32'(rx_sky),        32'h2A);

      d0 = done_cnt;
      send(4'd0, 12'h011, acc);
      wait_frame_end(d0);
      check("post_rst_sky",  32'(rx_sky),  32'h11);
      check("post_rst_done", 32'(done_cyc - acc), 32'(1 + DIV * 21));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation still running at %0t", $time);
      $fatal(1);
   end

endmodule
